// File: rtl/adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// adder_arbiter_if
//
// Purpose:
//    Bundles the requester-side and consumer-side handshake signals of the
//    shared adder/subtractor arbiter into one interface.
//
// Signals:
//    req_valid  per-requester operation valid
//    req_ready  per-requester accept (at most one bit high)
//    req_a      operand A, requester i at [i*WIDTH +: WIDTH]
//    req_b      operand B, same packing
//    req_sub    per-requester 1 = A - B, 0 = A + B
//    rsp_valid  result register holds a result
//    rsp_ready  consumer takes the result
//    rsp_id     requester that issued the result
//    rsp_sum    result, modulo 2^WIDTH
//    rsp_carry  carry-out; for subtract, 1 means no borrow
//
// Modports:
//    slave   the arbiter itself
//    master  the requesters plus the result consumer
// ---------------------------------------------------------------------------
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//    Shares one WIDTH-bit adder/subtractor among NUM_REQ requesters with a
//    round-robin grant.  One operation is accepted per cycle; its result is
//    held in a one-entry output register, tagged with the requester id,
//    until the consumer takes it.  A drain and a new accept may happen in
//    the same cycle, so a continuously ready consumer sees one result per
//    cycle.
//
// Ports:
//    clk  system clock, all logic on the rising edge
//    rst  synchronous, active-high reset
//    bus  adder_arbiter_if.slave (request and response handshakes)
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    adder_arbiter_if.slave      bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grantId;
    logic               w_anyValid;
    logic               w_canAccept;
    logic               w_accept;
    logic [IDW-1:0]     w_ptrNext;

    logic [WIDTH-1:0]   w_opA;
    logic [WIDTH-1:0]   w_opB;
    logic               w_sub;
    logic [WIDTH:0]     w_result;

    // Round-robin search: walk the requesters starting at the pointer and
    // wrapping past NUM_REQ-1, granting the first one found valid.  The
    // index is kept one bit wider so the wrap works for non-power-of-two
    // requester counts.
    always_comb begin
        logic [IDW:0] slot;
        w_grant    = '0;
        w_grantId  = '0;
        w_anyValid = 1'b0;
        slot       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, r_ptr} + (IDW+1)'(k);
            if (slot >= (IDW+1)'(NUM_REQ)) begin
                slot = slot - (IDW+1)'(NUM_REQ);
            end
            if (!w_anyValid && bus.req_valid[slot[IDW-1:0]]) begin
                w_anyValid             = 1'b1;
                w_grantId              = slot[IDW-1:0];
                w_grant[slot[IDW-1:0]] = 1'b1;
            end
        end
    end

    // The output register can take a new result when it is empty or being
    // drained this very cycle; reset blocks every accept.
    assign w_canAccept   = (r_state == EMPTY) || bus.rsp_ready;
    assign w_accept      = w_anyValid && w_canAccept && !rst;
    assign bus.req_ready = w_grant & {NUM_REQ{w_canAccept && !rst}};

    // The pointer moves to the slot after the winner so the winner becomes
    // the lowest priority on the next search.
    assign w_ptrNext = (w_grantId == IDW'(NUM_REQ-1)) ? '0 : w_grantId + IDW'(1);

    // Operand mux driven by the one-hot grant; constant slices keep the
    // selection simple for synthesis.
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        w_sub = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_opA = bus.req_a[k*WIDTH +: WIDTH];
                w_opB = bus.req_b[k*WIDTH +: WIDTH];
                w_sub = bus.req_sub[k];
            end
        end
    end

    // Subtraction is A + ~B + 1, so the carry-out reads as "no borrow".
    assign w_result = {1'b0, w_opA}
                    + {1'b0, (w_sub ? ~w_opB : w_opB)}
                    + {{WIDTH{1'b0}}, w_sub};

    // State register for the EMPTY/FULL occupancy of the result slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: an accept always leaves the slot FULL (covering the
    // drain-and-refill case); a drain with no accept empties it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_nextState = FULL;
                end
            end
            FULL: begin
                if (w_accept) begin
                    w_nextState = FULL;
                end else if (bus.rsp_ready) begin
                    w_nextState = EMPTY;
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    // Result register and round-robin pointer only change on an accept,
    // which keeps the response stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_ptr   <= w_ptrNext;
            r_id    <= w_grantId;
            r_sum   <= w_result[WIDTH-1:0];
            r_carry <= w_result[WIDTH];
        end
    end

    assign bus.rsp_valid = (r_state == FULL);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_carry = r_carry;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 32-bit adder/subtractor among NUM_REQ requesters. These include PC-increment, branch-target and address-generation clients in the RISC-V core. It accepts one operation per cycle through a valid/ready handshake and computes it in a single adder stage. Each result is held in a one-entry output register, tagged with the requester id, until the consumer takes it.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and result width
- IDW, $clog2(NUM_REQ), requester id width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_sub  in  NUM_REQ  1 = A − B, 0 = A + B
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  IDW  requester that issued the result
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH
- rsp_carry  out  1  carry-out of the WIDTH-bit add; for subtract, 1 means no borrow

## Operation
- State is EMPTY when rsp_valid is 0 and FULL when rsp_valid is 1.
- can_accept = !rsp_valid | rsp_ready. The output register is free this cycle, or it is being drained this cycle.
- Round-robin pointer ptr (IDW bits):
  - The grant goes to the first i with req_valid[i], searching ptr, ptr+1, … NUM_REQ−1, 0, … ptr−1.
  - req_ready[i] = grant[i] & can_accept. This is combinational from req_valid, ptr, rsp_valid and rsp_ready.
  - No requester is granted when req_valid is all zero.
- Accept happens when req_valid[g] & req_ready[g]. On accept:
  - Compute {carry, sum} = A + (sub ? ~B : B) + sub, at WIDTH+1 bits.
  - Load rsp_sum, rsp_carry and rsp_id = g.
  - Set rsp_valid = 1.
  - Set ptr = g+1, wrapping NUM_REQ−1 → 0.
- Drain happens when rsp_valid & rsp_ready with no accept in the same cycle. On drain, rsp_valid clears.
- Drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1. This gives a throughput of one operation per cycle.
- FULL and rsp_ready=0:
  - All req_ready bits are 0.
  - rsp_sum, rsp_id and rsp_carry hold stable.
  - ptr is unchanged.
- ptr changes only on accept. A requester that drops req_valid before being accepted loses its turn without penalty.
- Requesters must hold req_valid, operands and req_sub stable until accepted. The block does not check this.
- Unused requester slots have no special handling. Tie their req_valid to 0.

## Timing
- Latency: an operation accepted at edge T has rsp_valid=1 with its result visible after edge T.
- Result hold: rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
- Fairness: a continuously requesting client is accepted within NUM_REQ accepts. With rsp_ready held at 1, that is within NUM_REQ cycles.
- Reset clears all state at the clock edge where rst=1:
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, ptr=0.
- Reset while FULL discards the pending result. Reset on an accept cycle discards the operation; rst has priority over accept and drain.
- While rst=1, req_ready is all 0.
- Arithmetic wraps silently; overflow is visible only through rsp_carry.

## Test plan
- Single add: after reset, requester 2 drives A=5, B=7, sub=0 at cycle 1 → req_ready[2]=1 at cycle 1; at cycle 2 rsp_valid=1, rsp_id=2, rsp_sum=12, rsp_carry=0.
- Wrap and subtract, each accepted on its own cycle:
  - 0xFFFFFFFF + 0x00000001 → sum 0x00000000, carry 1.
  - 3 − 5 → sum 0xFFFFFFFE, carry 0.
  - 9 − 9 → sum 0, carry 1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: result pending with rsp_ready=0 for 3 cycles and requesters 1 and 3 valid → req_ready all 0, rsp_* unchanged. When rsp_ready rises, the same cycle accepts the next requester at or after ptr, and its result appears the following cycle.
- Simultaneous drain and accept: FULL with id 0, rsp_ready=1, requester 1 valid → rsp_valid stays 1 and the next cycle shows id 1 with no bubble.
- Reset mid-operation: rst=1 while FULL and on an accepting cycle → next cycle rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0. The first post-reset grant with all requesters valid goes to 0.
